// File: rtl/myreg_pipe.sv
// myreg_pipe: CH-channel, DEPTH-stage enabled register pipeline with per-stage valid, masking, flush and occupancy
module myreg_pipe #(
    parameter int WIDTH = 8,
    parameter int CH = 2,
    parameter int DEPTH = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [CH-1:0]       chan_mask,
    input  logic [CH*WIDTH-1:0] datain,
    output logic [CH*WIDTH-1:0] dout,
    output logic                out_valid,
    output logic [OW-1:0]       occupancy,
    output logic [CH-1:0]       chg
);
    logic [CH*WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]    r_v;
    logic [CH-1:0]       r_chg;
    logic [OW-1:0]       r_occ;
    logic [CH*WIDTH-1:0] w_nd [DEPTH];
    logic [DEPTH-1:0]    w_nv;
    logic [CH-1:0]       w_chg;
    logic [OW-1:0]       w_cnt;
    always_comb begin
        for (int c = 0; c < CH; c++)
            w_nd[0][c*WIDTH +: WIDTH] = chan_mask[c] ? datain[c*WIDTH +: WIDTH] : r_data[0][c*WIDTH +: WIDTH];
        w_nv[0] = in_valid;
        for (int k = 1; k < DEPTH; k++) begin
            w_nd[k] = r_data[k-1];
            w_nv[k] = r_v[k-1];
        end
        for (int c = 0; c < CH; c++)
            w_chg[c] = w_nd[DEPTH-1][c*WIDTH +: WIDTH] != r_data[DEPTH-1][c*WIDTH +: WIDTH];
        w_cnt = '0;
        for (int k = 0; k < DEPTH; k++)
            w_cnt = w_cnt + OW'(w_nv[k]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                r_data[k] <= {CH{RESET_VAL}};
            r_v   <= '0;
            r_chg <= '0;
            r_occ <= '0;
        end else if (flush) begin
            r_v   <= '0;
            r_chg <= '0;
            r_occ <= '0;
        end else if (en) begin
            r_data <= w_nd;
            r_v    <= w_nv;
            r_chg  <= w_chg;
            r_occ  <= w_cnt;
        end
    end
    assign dout      = r_data[DEPTH-1];
    assign out_valid = r_v[DEPTH-1];
    assign occupancy = r_occ;
    assign chg       = r_chg;
endmodule

// File: tb/tb_myreg_pipe.sv
// tb_myreg_pipe: directed vector table plus hand sequences for flush and reset dominance
module tb_myreg_pipe;
    logic        clk = 0;
    logic        rst = 1, en = 0, flush = 0, in_valid = 0;
    logic [1:0]  chan_mask = '0;
    logic [15:0] datain = '0;
    logic [15:0] dout;
    logic        out_valid;
    logic [1:0]  occupancy;
    logic [1:0]  chg;
    int total = 0, bad = 0;

    myreg_pipe #(.WIDTH(8), .CH(2), .DEPTH(3), .RESET_VAL(8'h5A)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .chan_mask(chan_mask), .datain(datain), .dout(dout),
        .out_valid(out_valid), .occupancy(occupancy), .chg(chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, flush, iv;
        logic [1:0]  mask;
        logic [15:0] din, e_dout;
        logic        e_ov;
        logic [1:0]  e_occ, e_chg;
    } vec_t;

    vec_t tbl [15];

    task automatic step(input logic r, input logic e, input logic f, input logic iv,
                        input logic [1:0] m, input logic [15:0] d);
        rst = r; en = e; flush = f; in_valid = iv; chan_mask = m; datain = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] ed, input logic eov,
                       input logic [1:0] eocc, input logic [1:0] echg);
        total += 4;
        if (dout !== ed) begin bad++; $display("FAIL %s dout got=%h want=%h", nm, dout, ed); end
        if (out_valid !== eov) begin bad++; $display("FAIL %s out_valid got=%b want=%b", nm, out_valid, eov); end
        if (occupancy !== eocc) begin bad++; $display("FAIL %s occupancy got=%0d want=%0d", nm, occupancy, eocc); end
        if (chg !== echg) begin bad++; $display("FAIL %s chg got=%b want=%b", nm, chg, echg); end
    endtask

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h5A5A, 1'b0, 2'd0, 2'b00},
            '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h5A5A, 1'b0, 2'd0, 2'b00},
            '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0102, 16'h5A5A, 1'b0, 2'd1, 2'b00},
            '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0304, 16'h5A5A, 1'b0, 2'd2, 2'b00},
            '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0506, 16'h0102, 1'b1, 2'd3, 2'b11},
            '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'hFFFF, 16'h0102, 1'b1, 2'd3, 2'b11},
            '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'hFFFF, 16'h0102, 1'b1, 2'd3, 2'b11},
            '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'hFFFF, 16'h0102, 1'b1, 2'd3, 2'b11},
            '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'hFFFF, 16'h0102, 1'b1, 2'd3, 2'b11},
            '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'hAABB, 16'h0304, 1'b1, 2'd3, 2'b11},
            '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'h1122, 16'h0506, 1'b1, 2'd3, 2'b11},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'hAABB, 1'b1, 2'd2, 2'b11},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'hAA22, 1'b1, 2'd1, 2'b01},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'hAA22, 1'b0, 2'd0, 2'b00},
            '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'hFFFF, 16'hAA22, 1'b0, 2'd1, 2'b00}
        };
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].flush, tbl[i].iv, tbl[i].mask, tbl[i].din);
            chk($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_ov, tbl[i].e_occ, tbl[i].e_chg);
        end
        // Flush with a full pipe: valids drop, data stays, new word takes full latency
        step(0, 1, 0, 1, 2'b11, 16'h1111);
        step(0, 1, 0, 1, 2'b11, 16'h2222);
        step(0, 1, 0, 1, 2'b11, 16'h3333);
        chk("fill3", 16'h1111, 1'b1, 2'd3, 2'b11);
        step(0, 1, 1, 1, 2'b11, 16'h4444);
        chk("flush", 16'h1111, 1'b0, 2'd0, 2'b00);
        step(0, 1, 0, 1, 2'b11, 16'h5555);
        chk("post_flush1", 16'h2222, 1'b0, 2'd1, 2'b11);
        step(0, 1, 0, 0, 2'b00, 16'h0000);
        chk("post_flush2", 16'h3333, 1'b0, 2'd1, 2'b11);
        step(0, 1, 0, 0, 2'b00, 16'h0000);
        chk("post_flush3", 16'h5555, 1'b1, 2'd1, 2'b11);
        // Reset beats flush and enable with a word in flight
        step(0, 1, 0, 1, 2'b11, 16'h6666);
        chk("inflight", 16'h5555, 1'b0, 2'd1, 2'b00);
        step(1, 1, 1, 1, 2'b11, 16'h7777);
        chk("rst_dom", 16'h5A5A, 1'b0, 2'd0, 2'b00);
        step(0, 1, 0, 0, 2'b00, 16'h0000);
        chk("rst_after", 16'h5A5A, 1'b0, 2'd0, 2'b00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
